// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand issuer: FSM state encoding,
// ALU function codes and the bit positions inside the 4-bit flag vector.
package alu_pkg;

    typedef enum logic [2:0] {
        GET_A  = 3'd0,
        GET_B  = 3'd1,
        GET_F  = 3'd2,
        WAIT   = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [3:0] FN_ADD   = 4'b0000;
    localparam logic [3:0] FN_SUB   = 4'b0001;
    localparam logic [3:0] FN_AND   = 4'b0100;
    localparam logic [3:0] FN_OR    = 4'b0101;
    localparam logic [3:0] FN_XOR   = 4'b0110;
    localparam logic [3:0] FN_SHL   = 4'b1000;
    localparam logic [3:0] FN_SHR   = 4'b1001;
    localparam logic [3:0] FN_ASR   = 4'b1010;
    localparam logic [3:0] FN_PASSB = 4'b1111;

    localparam int FLAG_ZE = 3;
    localparam int FLAG_N  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;

endpackage

// File: rtl/alu_func_legal.sv
// Combinational decode of the ALU function codes the issuer is allowed to
// forward; used only when ALU_ISSUER_OPCHK_EN is defined.
module alu_func_legal
    import alu_pkg::*;
(
    input  logic [3:0] i_func,
    output logic       o_legal
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        o_legal = 1'b0;
        case (i_func)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
            FN_SHL, FN_SHR, FN_ASR, FN_PASSB: o_legal = 1'b1;
            default:                          o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_op_issuer.sv
// Collects A, B and function nibbles, holds them on the ALU for SETTLE_CYCLES,
// then presents the captured result. Optional opcode check: ALU_ISSUER_OPCHK_EN.
module alu_op_issuer
    import alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_func,
    input  logic [3:0] alu_y,
    input  logic [3:0] alu_flags,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [3:0] res_flags,
    output logic       res_err
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_settle_cnt;
    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [3:0] r_alu_func;
    logic [3:0] r_res_data;
    logic [3:0] r_res_flags;
    logic       w_in_xfer;
    logic       w_func_xfer;
    logic       w_func_legal;
    logic       w_wait_done;

    assign in_ready    = (r_state == GET_A) || (r_state == GET_B) || (r_state == GET_F);
    assign res_valid   = (r_state == RESULT);
    assign w_in_xfer   = in_valid && in_ready;
    assign w_func_xfer = w_in_xfer && (r_state == GET_F);
    assign w_wait_done = (r_state == WAIT) && (r_settle_cnt == 4'd0);

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_func  = r_alu_func;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;

`ifdef ALU_ISSUER_OPCHK_EN
    logic r_res_err;

    alu_func_legal u_func_legal (
        .i_func  (in_data),
        .o_legal (w_func_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_err <= 1'b0;
        end else if (w_func_xfer) begin
            r_res_err <= !w_func_legal;
        end
    end

    assign res_err = r_res_err;
`else
    assign w_func_legal = 1'b1;
    assign res_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= GET_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            GET_A:   if (w_in_xfer) w_next_state = GET_B;
            GET_B:   if (w_in_xfer) w_next_state = GET_F;
            GET_F:   if (w_in_xfer) w_next_state = w_func_legal ? WAIT : RESULT;
            WAIT:    if (r_settle_cnt == 4'd0) w_next_state = RESULT;
            RESULT:  if (res_ready) w_next_state = GET_A;
            default: w_next_state = GET_A;
        endcase
    end

    // Counter is loaded at the function transfer and only decrements while non-zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= 4'd0;
        end else if (w_func_xfer) begin
            r_settle_cnt <= SETTLE_INIT;
        end else if ((r_state == WAIT) && (r_settle_cnt != 4'd0)) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_a     <= 4'd0;
            r_alu_b     <= 4'd0;
            r_alu_func  <= 4'd0;
            r_res_data  <= 4'd0;
            r_res_flags <= 4'd0;
        end else begin
            if (w_in_xfer && (r_state == GET_A)) r_alu_a <= in_data;
            if (w_in_xfer && (r_state == GET_B)) r_alu_b <= in_data;
            if (w_func_xfer && w_func_legal)     r_alu_func <= in_data;

            // An illegal code goes straight to RESULT with a zeroed result.
            if (w_func_xfer && !w_func_legal) begin
                r_res_data  <= 4'd0;
                r_res_flags <= 4'd0;
            end else if (w_wait_done) begin
                r_res_data  <= alu_y;
                r_res_flags <= alu_flags;
            end
        end
    end

endmodule
